mips32_fetch_queue: RTL and testbench
=====================================

# mips32_fetch_queue

Instruction fetch front end for the pipelined MIPS32 core. It holds the PC, issues word-addressed requests to instruction memory with a valid/ready handshake, and buffers in-order responses in a small prefetch queue. It presents `{IR, NPC}` pairs to the IF/ID register and flushes on taken-branch redirects from EX/MEM. Prefetching stops once an HLT opcode is fetched.

## Interface
- `DEPTH`, 4: prefetch queue entries; power of two, ≥2.
- `AW`, 10: instruction word-address width; 1024-word memory.
- `RESET_PC`, 0: PC after reset, AW bits.

- `clk1`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  AW  word address of request.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_rsp_valid`  in  1  response word valid; responses in request order.
- `imem_rsp_data`  in  32  fetched instruction.
- `redirect_valid`  in  1  taken branch; one-cycle pulse.
- `redirect_pc`  in  AW  branch target word address.
- `out_valid`  out  1  queue head valid.
- `out_ir`  out  32  head instruction.
- `out_npc`  out  32  head address + 1, zero-extended.
- `out_ready`  in  1  IF/ID consumes head.
- `halted`  out  1  FSM in HALT.

## Operation
- Registered state:
  - `pc` (AW)
  - `outstanding` (0..DEPTH): accepted requests without a response.
  - `stale` (0..DEPTH): outstanding responses to discard.
  - queue of `{npc, ir}`
  - FSM.
- FSM states: FETCH, HALT.
  - FETCH→HALT: a non-stale response with `imem_rsp_data[31:26]==6'h3F` is enqueued.
  - HALT→FETCH: `redirect_valid` only.
- Issue rule: `imem_req_valid = (state==FETCH) && (occupancy + outstanding < DEPTH)`.
  - `imem_req_addr = pc`.
  - On accept: `pc <= pc+1`, wrapping mod 2^AW; `outstanding++`.
- Response handling:
  - `stale>0`: drop the word, `stale--`.
  - Otherwise push `{pc_of_request+1, data}`.
  - `outstanding--` in both cases.
  - Each request's address is carried in a shadow address FIFO of DEPTH entries.
- Redirect:
  - Queue cleared.
  - `pc <= redirect_pc`; state → FETCH.
  - `stale <=` outstanding after this cycle's accept/response updates. A request accepted in the redirect cycle is counted stale.
  - `imem_req_valid` does not depend combinationally on `redirect_valid`.
- HLT entry: `stale <=` the remaining outstanding count, so younger words are dropped. The HLT word itself is delivered.
- Simultaneous events:
  - Push and pop in the same cycle on a full queue is legal.
  - Redirect with `out_ready && out_valid`: the pop counts as delivered, then the flush applies.
  - Redirect overrides the HLT transition in the same cycle.
- The credit rule guarantees the queue never overflows. A response arriving with `outstanding==0` is a protocol error; assert in simulation.

## Timing
- Reset values:
  - `imem_req_valid=0` while reset is high.
  - `out_valid=0`, `out_ir=0`, `out_npc=0`, `halted=0`.
  - `pc=RESET_PC`, counters 0, state FETCH.
- First request is valid in the first cycle after reset deassertion.
- Response at cycle t gives `out_valid` at t+1; there is no bypass.
- Memory latency is unconstrained (≥1 cycle after accept) but in order.
- Redirect at cycle t:
  - `out_valid=0` at t+1.
  - First request to `redirect_pc` at t+1.
  - Earliest valid target output at t+3 with single-cycle memory.
- Reset mid-operation clears everything immediately. The bench must not drive stale responses after reset.

## Structure
- `mips32_pkg`: opcode constants (ADD..BEQZ, HLT=6'h3F), instruction-type codes, FSM state typedef. Shared with the pipeline.
- Sub-module `mips32_sync_fifo`: parameterised width/depth, with push, pop, flush, and occupancy outputs. Instantiated twice:
  - instruction queue, width 32+32
  - request-address shadow, width AW

## Test plan
- Reset, `imem_req_ready=1`, memory with 1-cycle latency holding words 0x00000000+i → `out_npc` 1,2,3,4… with matching IR, `out_valid` from cycle 3.
- Hold `out_ready=0` → exactly DEPTH=4 requests (addr 0–3), then `imem_req_valid=0` until a pop, then addr 4 issues.
- 3-cycle memory latency, redirect to 0x100 with 3 outstanding → those 3 responses dropped, next delivered `out_npc=0x101`.
- Word at addr 5 = 0xFC000000 (HLT) → delivered with `out_npc=6`, `halted=1`, no request ≥ addr 6 delivered, `imem_req_valid=0`; a later redirect to 0 resumes fetch.
- Redirect in the same cycle as a pop and as a request accept → popped word delivered once, the accepted request is dropped on return, queue empty next cycle.
- Assert reset mid-stream with 2 outstanding → all outputs at reset values, first post-reset request at `RESET_PC`.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcodes, instruction classes and the fetch FSM state type.
// Used by the fetch front end and the downstream pipeline stages.
package mips32_pkg;

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_AND   = 6'h02;
    localparam logic [5:0] OP_OR    = 6'h03;
    localparam logic [5:0] OP_SLT   = 6'h04;
    localparam logic [5:0] OP_MUL   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h08;
    localparam logic [5:0] OP_SW    = 6'h09;
    localparam logic [5:0] OP_ADDI  = 6'h0A;
    localparam logic [5:0] OP_SUBI  = 6'h0B;
    localparam logic [5:0] OP_SLTI  = 6'h0C;
    localparam logic [5:0] OP_BNEQZ = 6'h0D;
    localparam logic [5:0] OP_BEQZ  = 6'h0E;
    localparam logic [5:0] OP_HLT   = 6'h3F;

    typedef enum logic [2:0] {
        IT_RR_ALU,
        IT_RM_ALU,
        IT_LOAD,
        IT_STORE,
        IT_BRANCH,
        IT_HALT
    } instr_type_t;

    typedef enum logic {
        FETCH,
        HALT
    } fetch_state_t;

    function automatic logic is_halt(input logic [31:0] ir);
        return ir[31:26] == OP_HLT;
    endfunction

    // Unknown opcodes decode as register-register ALU ops; the decoder flags them separately.
    function automatic instr_type_t decode_type(input logic [5:0] op);
        instr_type_t t;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = IT_RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     t = IT_RM_ALU;
            OP_LW:                                         t = IT_LOAD;
            OP_SW:                                         t = IT_STORE;
            OP_BNEQZ, OP_BEQZ:                             t = IT_BRANCH;
            OP_HLT:                                        t = IT_HALT;
            default:                                       t = IT_RR_ALU;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mips32_sync_fifo.sv
// Small synchronous FIFO with flush and occupancy count; DEPTH must be a power of two.
// Storage is not reset, so the head word is only meaningful while count is non-zero.
module mips32_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk1,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk1) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction fetch front end: PC, credit-limited memory requests, prefetch queue,
// branch redirect flush and halt-on-HLT.
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int            DEPTH    = 4,
    parameter int            AW       = 10,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk1,
    input  logic          reset,
    output logic          imem_req_valid,
    output logic [AW-1:0] imem_req_addr,
    input  logic          imem_req_ready,
    input  logic          imem_rsp_valid,
    input  logic [31:0]   imem_rsp_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          out_valid,
    output logic [31:0]   out_ir,
    output logic [31:0]   out_npc,
    input  logic          out_ready,
    output logic          halted
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state, state_next;
    logic [AW-1:0] pc;
    logic [CW-1:0] occupancy, outstanding, outstanding_next, stale, stale_next;
    logic [AW-1:0] rsp_addr;
    logic [63:0]   q_head;
    logic          req_accept, push, pop, hlt_enq;

    // Queue slots plus in-flight requests never exceed DEPTH, so a response always has room.
    assign imem_req_valid = !reset && (state == FETCH) &&
                            (({1'b0, occupancy} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_accept     = imem_req_valid && imem_req_ready;

    assign push    = imem_rsp_valid && (stale == '0) && !redirect_valid;
    assign pop     = out_valid && out_ready;
    assign hlt_enq = push && is_halt(imem_rsp_data);
    assign outstanding_next = outstanding + CW'(req_accept) - CW'(imem_rsp_valid);

    always_comb begin
        state_next = state;
        stale_next = stale;
        if (imem_rsp_valid && (stale != '0)) stale_next = stale - CW'(1);
        // Everything still in flight after a redirect or an HLT belongs to the abandoned path.
        if (redirect_valid) begin
            state_next = FETCH;
            stale_next = outstanding_next;
        end else if (hlt_enq) begin
            state_next = HALT;
            stale_next = outstanding_next;
        end
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            stale <= '0;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            stale <= stale_next;
            if (redirect_valid)  pc <= redirect_pc;
            else if (req_accept) pc <= pc + AW'(1);
        end
    end

    mips32_sync_fifo #(.WIDTH(AW), .DEPTH(DEPTH)) u_addr_shadow (
        .clk1      (clk1),
        .reset     (reset),
        .push      (req_accept),
        .push_data (pc),
        .pop       (imem_rsp_valid),
        .flush     (1'b0),
        .head      (rsp_addr),
        .count     (outstanding)
    );

    mips32_sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_instr_queue (
        .clk1      (clk1),
        .reset     (reset),
        .push      (push),
        .push_data ({{(32-AW){1'b0}}, rsp_addr + AW'(1), imem_rsp_data}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (q_head),
        .count     (occupancy)
    );

    assign out_valid = (occupancy != '0);
    assign out_ir    = out_valid ? q_head[31:0]  : '0;
    assign out_npc   = out_valid ? q_head[63:32] : '0;
    assign halted    = (state == HALT);

    always @(posedge clk1) begin
        assert (!(imem_rsp_valid && (outstanding == '0)));
    end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Self-checking bench for mips32_fetch_queue: in-order memory model plus a program-order
// reference stream (sequential from the last redirect, ending after an HLT).
module tb_mips32_fetch_queue;
    localparam int            DEPTH    = 4;
    localparam int            AW       = 10;
    localparam logic [AW-1:0] RESET_PC = '0;

    logic          clk1 = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_req_ready = 1'b0;
    logic          imem_rsp_valid = 1'b0;
    logic [31:0]   imem_rsp_data = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          out_valid;
    logic [31:0]   out_ir;
    logic [31:0]   out_npc;
    logic          out_ready = 1'b0;
    logic          halted;

    always #5 clk1 = ~clk1;

    mips32_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(RESET_PC)) dut (
        .clk1           (clk1),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ir         (out_ir),
        .out_npc        (out_npc),
        .out_ready      (out_ready),
        .halted         (halted)
    );

    int            n_vec = 0;
    int            n_err = 0;
    logic [31:0]   mem [1024];
    logic [AW-1:0] pend_addr [$];
    int            pend_due [$];
    int            cyc = 0;
    int            lat = 1;
    int            n_acc = 0;
    int            n_pops = 0;
    logic [31:0]   last_npc = '0;
    logic [AW-1:0] exp_req_addr, exp_addr;
    bit            stream_done = 0;
    bit            chk_flush = 0;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_req_addr = RESET_PC;
        exp_addr     = RESET_PC;
        stream_done  = 0;
        chk_flush    = 0;
        n_acc        = 0;
        n_pops       = 0;
        pend_addr.delete();
        pend_due.delete();
    endtask

    // One clock cycle: memory answers, inputs are driven at the falling edge, outputs are
    // compared against the program-order model, then the rising edge commits.
    task automatic apply_stimulus(input bit rdy_out, input bit redir, input logic [AW-1:0] tgt,
                                  input bit req_rdy);
        logic [31:0] npc_exp;
        @(negedge clk1);
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem[pend_addr[0]];
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = req_rdy;
        out_ready      = rdy_out;
        redirect_valid = redir;
        redirect_pc    = tgt;
        #1;
        if (chk_flush) check_output("flush_empty", out_valid, 0);
        chk_flush = 0;
        if (stream_done) begin
            check_output("no_out_after_hlt", out_valid, 0);
        end else if (out_valid && out_ready) begin
            npc_exp = {{(32-AW){1'b0}}, AW'(exp_addr + 1)};
            check_output("out_npc", out_npc, npc_exp);
            check_output("out_ir", out_ir, mem[exp_addr]);
            if (mem[exp_addr][31:26] == 6'h3F) stream_done = 1;
            exp_addr = exp_addr + 1;
            last_npc = out_npc;
            n_pops++;
        end
        if (imem_req_valid && imem_req_ready) begin
            check_output("req_addr", imem_req_addr, exp_req_addr);
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + lat);
            exp_req_addr = exp_req_addr + 1;
            n_acc++;
        end
        if (redir) begin
            exp_addr     = tgt;
            exp_req_addr = tgt;
            stream_done  = 0;
            chk_flush    = 1;
        end
        @(posedge clk1);
        #1;
        cyc++;
    endtask

    task automatic apply_reset(input int n);
        reset          = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        imem_req_ready = 1'b0;
        model_reset();
        #1;
        check_output("rst_req_valid", imem_req_valid, 0);
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_out_ir", out_ir, 0);
        check_output("rst_out_npc", out_npc, 0);
        check_output("rst_halted", halted, 0);
        repeat (n) @(posedge clk1);
        #1;
        reset = 1'b0;
        #1;
        check_output("first_req_valid", imem_req_valid, 1);
        check_output("first_req_addr", imem_req_addr, RESET_PC);
        cyc = 0;
    endtask

    initial begin
        int first_valid;
        int halt_cycles;
        bit rdir;

        for (int i = 0; i < 1024; i++) mem[i] = i;
        #2;

        // Sequential fetch with single-cycle memory.
        apply_reset(2);
        lat = 1;
        first_valid = -1;
        for (int i = 0; i < 12; i++) begin
            if (out_valid && first_valid < 0) first_valid = cyc;
            apply_stimulus(1, 0, '0, 1);
        end
        check_output("first_out_valid_cycle", first_valid, 2);
        check_output("seq_pops", n_pops, 10);

        // Back-pressure: exactly DEPTH requests, then one more after a pop.
        apply_reset(2);
        repeat (8) apply_stimulus(0, 0, '0, 1);
        check_output("bp_accepts", n_acc, DEPTH);
        check_output("bp_req_valid", imem_req_valid, 0);
        apply_stimulus(1, 0, '0, 1);
        check_output("bp_resume_valid", imem_req_valid, 1);
        check_output("bp_resume_addr", imem_req_addr, 4);
        repeat (8) apply_stimulus(1, 0, '0, 1);

        // Redirect with three requests in flight on a 3-cycle memory.
        apply_reset(2);
        lat = 3;
        apply_stimulus(0, 0, '0, 1);
        apply_stimulus(0, 0, '0, 1);
        apply_stimulus(0, 1, 10'h100, 1);
        check_output("redir_in_flight", pend_addr.size(), 3);
        for (int i = 0; i < 20 && n_pops == 0; i++) apply_stimulus(1, 0, '0, 1);
        check_output("redir_first_npc", last_npc, 32'h101);
        repeat (6) apply_stimulus(1, 0, '0, 1);

        // HLT at word 5 stops prefetch until a redirect.
        mem[5] = 32'hFC00_0000;
        apply_reset(2);
        lat = 1;
        for (int i = 0; i < 30 && !stream_done; i++) apply_stimulus(1, 0, '0, 1);
        check_output("hlt_delivered", stream_done, 1);
        check_output("hlt_npc", last_npc, 6);
        check_output("hlt_halted", halted, 1);
        for (int i = 0; i < 6; i++) begin
            check_output("hlt_req_idle", imem_req_valid, 0);
            apply_stimulus(1, 0, '0, 1);
        end
        apply_stimulus(1, 1, '0, 1);
        check_output("resume_halted", halted, 0);
        check_output("resume_req_valid", imem_req_valid, 1);
        check_output("resume_req_addr", imem_req_addr, 0);
        repeat (4) apply_stimulus(1, 0, '0, 1);
        mem[5] = 32'h5;

        // Redirect coinciding with a pop and a request accept.
        apply_reset(2);
        lat = 2;
        for (int i = 0; i < 20 && !(out_valid && imem_req_valid); i++) apply_stimulus(0, 0, '0, 1);
        check_output("collide_setup", out_valid && imem_req_valid, 1);
        apply_stimulus(1, 1, 10'h200, 1);
        check_output("collide_pop_npc", last_npc, 1);
        n_pops = 0;
        for (int i = 0; i < 20 && n_pops == 0; i++) apply_stimulus(1, 0, '0, 1);
        check_output("collide_next_npc", last_npc, 32'h201);

        // Reset mid-stream with two requests outstanding.
        apply_reset(2);
        lat = 3;
        apply_stimulus(1, 0, '0, 1);
        apply_stimulus(1, 0, '0, 1);
        check_output("midrst_in_flight", pend_addr.size(), 2);
        apply_reset(2);
        repeat (10) apply_stimulus(1, 0, '0, 1);

        // Randomised traffic over a random program with scattered HLTs.
        for (int i = 0; i < 1024; i++) mem[i] = {6'($urandom_range(0, 62)), 26'($urandom)};
        for (int i = 0; i < 6; i++) mem[$urandom_range(0, 80)][31:26] = 6'h3F;
        mem[1023][31:26] = 6'h01;
        apply_reset(2);
        halt_cycles = 0;
        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) lat = $urandom_range(1, 3);
            halt_cycles = halted ? halt_cycles + 1 : 0;
            rdir = ($urandom_range(0, 24) == 0) || (halt_cycles > 6);
            apply_stimulus($urandom_range(0, 3) != 0, rdir,
                           ($urandom_range(0, 3) == 0) ? AW'(1020) : AW'($urandom_range(0, 60)),
                           $urandom_range(0, 9) < 7);
        end
        apply_reset(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
